// File: rtl/uart_sram_cmd_pkg.sv
// Shared definitions for the UART-to-SRAM command parser: FSM state
// encoding, default opcodes and the default inter-byte timeout.
package uart_sram_cmd_pkg;

  localparam logic [7:0] OP_WRITE_DEF       = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ_DEF        = 8'h52;  // 'R'
  localparam int         TIMEOUT_CYCLES_DEF = 1_200_000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADR2    = 3'd1,
    ST_ADR1    = 3'd2,
    ST_ADR0    = 3'd3,
    ST_DATA    = 3'd4,
    ST_WAIT_WR = 3'd5,
    ST_WAIT_RD = 3'd6
  } state_e;

  // True while a frame is being assembled (bytes still expected).
  function automatic logic in_frame(state_e s);
    return s inside {ST_ADR2, ST_ADR1, ST_ADR0, ST_DATA};
  endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// Inter-byte timeout counter for uart_sram_cmd. Only compiled when
// CMD_TIMEOUT_EN is defined, so the default build carries no dead module.
`ifdef CMD_TIMEOUT_EN
module cmd_timeout_counter #(
  parameter int CYCLES = 1_200_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(CYCLES);

  logic [W-1:0] cnt_q;

  assign expired = run && (cnt_q == W'(CYCLES - 1));

  // Count while running, hold otherwise; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/uart_sram_cmd.sv
// Command parser between uart_rx and sram_23lc1024.
// Frames: opcode, A2, A1, A0 (MSB first), then D for writes only.
// Optional feature macro: CMD_TIMEOUT_EN (inter-byte timeout aborts a
// partial frame back to IDLE with an error pulse).
//
// Handshake: rx_received is a one-cycle valid strobe with no ready/backpressure;
// a byte arriving while a transaction is outstanding is dropped and flagged
// as an overrun. sram_wr_en/sram_rd_en are one-cycle request strobes, and
// sram_completed is the one-cycle acknowledge that ends the transaction.
module uart_sram_cmd
  import uart_sram_cmd_pkg::*;
#(
  parameter logic [7:0] OP_WRITE       = OP_WRITE_DEF,
  parameter logic [7:0] OP_READ        = OP_READ_DEF,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_received,
  output logic        sram_wr_en,
  output logic        sram_rd_en,
  output logic [23:0] sram_address,
  output logic [7:0]  sram_wdata,
  input  logic [7:0]  sram_rdata,
  input  logic        sram_completed,
  output logic [7:0]  result_data,
  output logic        result_valid,
  output logic        busy,
  output logic        error
);

  state_e      state_q, state_d;
  logic        is_read_q, is_read_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  result_q, result_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic        err_q, err_d;
  logic        rv_q, rv_d;
  logic        tmo_expired;

`ifdef CMD_TIMEOUT_EN
  logic tmo_clear;
  logic tmo_run;

  // Restart the window on each frame byte, and after an expiry so the next
  // frame starts from zero.
  assign tmo_run   = in_frame(state_q);
  assign tmo_clear = tmo_run && (rx_received || tmo_expired);

  cmd_timeout_counter #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .run     (tmo_run),
    .expired (tmo_expired)
  );
`else
  logic unused_timeout_cfg;

  // No timeout: a partial frame waits indefinitely.
  assign tmo_expired        = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // State and datapath registers; everything returns to zero / IDLE on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      result_q  <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      err_q     <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      result_q  <= result_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      err_q     <= err_d;
      rv_q      <= rv_d;
    end
  end

  // Frame parser: next state, latched fields and one-cycle pulses.
  always_comb begin
    state_d   = state_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    result_d  = result_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    err_d     = 1'b0;
    rv_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_received) begin
          if (rx_data == OP_WRITE) begin
            state_d   = ST_ADR2;
            is_read_d = 1'b0;
          end else if (rx_data == OP_READ) begin
            state_d   = ST_ADR2;
            is_read_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ADR2: begin
        if (rx_received) begin
          // Only bit 0 of A2 addresses the 128 KiB part.
          addr_d[16] = rx_data[0];
          state_d    = ST_ADR1;
        end
      end
      ST_ADR1: begin
        if (rx_received) begin
          addr_d[15:8] = rx_data;
          state_d      = ST_ADR0;
        end
      end
      ST_ADR0: begin
        if (rx_received) begin
          addr_d[7:0] = rx_data;
          if (is_read_q) begin
            rd_en_d = 1'b1;
            state_d = ST_WAIT_RD;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_received) begin
          wdata_d = rx_data;
          wr_en_d = 1'b1;
          state_d = ST_WAIT_WR;
        end
      end
      ST_WAIT_WR: begin
        err_d = rx_received;
        if (sram_completed) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RD: begin
        err_d = rx_received;
        if (sram_completed) begin
          result_d = sram_rdata;
          rv_d     = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A byte arriving in the same cycle as expiry keeps the frame alive.
    if (in_frame(state_q) && !rx_received && tmo_expired) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end

  assign sram_wr_en   = wr_en_q;
  assign sram_rd_en   = rd_en_q;
  assign sram_address = {7'b0, addr_q};
  assign sram_wdata   = wdata_q;
  assign result_data  = result_q;
  assign result_valid = rv_q;
  assign busy         = (state_q != ST_IDLE);
  assign error        = err_q;

endmodule

// File: tb/tb_uart_sram_cmd.sv
// Directed bench for uart_sram_cmd: a table of complete frames with
// hand-computed results, followed by hand-written corner-case sequences.
module tb_uart_sram_cmd;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_received;
  logic        sram_wr_en;
  logic        sram_rd_en;
  logic [23:0] sram_address;
  logic [7:0]  sram_wdata;
  logic [7:0]  sram_rdata;
  logic        sram_completed;
  logic [7:0]  result_data;
  logic        result_valid;
  logic        busy;
  logic        error;

  // Clock
  always #5 clk = ~clk;

  uart_sram_cmd #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data        (rx_data),
    .rx_received    (rx_received),
    .sram_wr_en     (sram_wr_en),
    .sram_rd_en     (sram_rd_en),
    .sram_address   (sram_address),
    .sram_wdata     (sram_wdata),
    .sram_rdata     (sram_rdata),
    .sram_completed (sram_completed),
    .result_data    (result_data),
    .result_valid   (result_valid),
    .busy           (busy),
    .error          (error)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;
  int rv_cnt = 0;
  logic [7:0] last_result = 8'h00;

  // Pulse counters (sampled before the edge updates the DUT)
  always @(posedge clk) begin
    if (sram_wr_en)   wr_cnt++;
    if (sram_rd_en)   rd_cnt++;
    if (error)        err_cnt++;
    if (result_valid) rv_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: one rx_received strobe; returns at the negedge after capture.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data     = b;
    rx_received = 1'b1;
    @(negedge clk);
    rx_received = 1'b0;
  endtask

  // SRAM model: completion pulse with read data, called at a negedge.
  task automatic complete(input logic [7:0] d);
    sram_rdata     = d;
    sram_completed = 1'b1;
    @(negedge clk);
    sram_completed = 1'b0;
  endtask

  typedef struct {
    logic [39:0] b;       // frame bytes, first byte in [39:32]
    int          n;
    logic [7:0]  rdata;
    logic        exp_wr;
    logic        exp_rd;
    logic [23:0] exp_addr;
    logic [7:0]  exp_wdata;
    int          exp_err;
  } vec_t;

  function automatic vec_t mk(logic [39:0] b, int n, logic [7:0] rdata, logic wr, logic rd,
                              logic [23:0] addr, logic [7:0] wdata, int err);
    vec_t v;
    v.b = b; v.n = n; v.rdata = rdata; v.exp_wr = wr; v.exp_rd = rd;
    v.exp_addr = addr; v.exp_wdata = wdata; v.exp_err = err;
    return v;
  endfunction

  vec_t vecs[7];

  initial begin
    int w0, r0, e0, v0;
    bit seen;

    vecs[0] = mk(40'h57_00_12_34_AB, 5, 8'h00, 1'b1, 1'b0, 24'h001234, 8'hAB, 0);
    vecs[1] = mk(40'h52_01_FF_FF_00, 4, 8'h5A, 1'b0, 1'b1, 24'h01FFFF, 8'h00, 0);
    vecs[2] = mk(40'h57_FF_00_01_77, 5, 8'h00, 1'b1, 1'b0, 24'h010001, 8'h77, 0);
    vecs[3] = mk(40'h41_00_00_00_00, 1, 8'h00, 1'b0, 1'b0, 24'h000000, 8'h00, 1);
    vecs[4] = mk(40'h52_00_00_00_00, 4, 8'h3C, 1'b0, 1'b1, 24'h000000, 8'h00, 0);
    vecs[5] = mk(40'h57_FE_80_00_00, 5, 8'h00, 1'b1, 1'b0, 24'h008000, 8'h00, 0);
    vecs[6] = mk(40'h00_00_00_00_00, 1, 8'h00, 1'b0, 1'b0, 24'h000000, 8'h00, 1);

    // Reset
    rst_n = 1'b0; rx_data = 8'h00; rx_received = 1'b0;
    sram_rdata = 8'h00; sram_completed = 1'b0;
    repeat (3) @(negedge clk);
    check("reset strobes", {30'd0, sram_wr_en, sram_rd_en}, 32'd0);
    check("reset address", sram_address, 32'd0);
    check("reset wdata", sram_wdata, 32'd0);
    check("reset result", {result_data, result_valid}, 32'd0);
    check("reset busy/error", {busy, error}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven frames
    for (int k = 0; k < 7; k++) begin
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; v0 = rv_cnt;
      for (int i = 0; i < vecs[k].n; i++) send_byte(vecs[k].b[39-8*i -: 8]);
      if (vecs[k].exp_wr || vecs[k].exp_rd) begin
        check($sformatf("v%0d wr_en at strobe", k), sram_wr_en, vecs[k].exp_wr);
        check($sformatf("v%0d rd_en at strobe", k), sram_rd_en, vecs[k].exp_rd);
        check($sformatf("v%0d address", k), sram_address, vecs[k].exp_addr);
        if (vecs[k].exp_wr) check($sformatf("v%0d wdata", k), sram_wdata, vecs[k].exp_wdata);
        check($sformatf("v%0d busy in wait", k), busy, 1'b1);
        @(negedge clk);
        check($sformatf("v%0d strobe width", k), {sram_wr_en, sram_rd_en}, 2'b00);
        repeat (2) @(negedge clk);
        check($sformatf("v%0d address held", k), sram_address, vecs[k].exp_addr);
        check($sformatf("v%0d busy held", k), busy, 1'b1);
        complete(vecs[k].rdata);
        check($sformatf("v%0d busy after done", k), busy, 1'b0);
        check($sformatf("v%0d result_valid", k), result_valid, vecs[k].exp_rd);
        if (vecs[k].exp_rd) last_result = vecs[k].rdata;
        check($sformatf("v%0d result_data", k), result_data, last_result);
        @(negedge clk);
        check($sformatf("v%0d result_valid width", k), result_valid, 1'b0);
      end else begin
        check($sformatf("v%0d error pulse", k), error, vecs[k].exp_err > 0);
        check($sformatf("v%0d busy stays low", k), busy, 1'b0);
      end
      repeat (2) @(negedge clk);
      check($sformatf("v%0d wr pulses", k), wr_cnt - w0, vecs[k].exp_wr);
      check($sformatf("v%0d rd pulses", k), rd_cnt - r0, vecs[k].exp_rd);
      check($sformatf("v%0d error pulses", k), err_cnt - e0, vecs[k].exp_err);
      check($sformatf("v%0d result pulses", k), rv_cnt - v0, vecs[k].exp_rd);
    end

    // Completion while IDLE is ignored
    v0 = rv_cnt;
    @(negedge clk);
    complete(8'hEE);
    check("idle completed rv", result_valid, 1'b0);
    check("idle completed busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    check("idle completed result held", result_data, last_result);
    check("idle completed rv count", rv_cnt - v0, 0);

    // Overrun during WAIT_RD: byte dropped, read still completes
    e0 = err_cnt; r0 = rd_cnt;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    check("overrun rd_en", sram_rd_en, 1'b1);
    send_byte(8'hC3);
    check("overrun error pulse", error, 1'b1);
    check("overrun busy", busy, 1'b1);
    complete(8'h99);
    last_result = 8'h99;
    check("overrun result_valid", result_valid, 1'b1);
    check("overrun result_data", result_data, 8'h99);
    repeat (3) @(negedge clk);
    check("overrun single error", err_cnt - e0, 1);
    check("overrun idle after", busy, 1'b0);
    check("overrun single rd", rd_cnt - r0, 1);

    // Byte and completion in the same WAIT_WR cycle
    e0 = err_cnt;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05); send_byte(8'h11);
    check("simul wr_en", sram_wr_en, 1'b1);
    check("simul wdata", sram_wdata, 8'h11);
    @(negedge clk);
    rx_data = 8'h22; rx_received = 1'b1;
    sram_completed = 1'b1;
    @(negedge clk);
    rx_received = 1'b0; sram_completed = 1'b0;
    check("simul busy dropped", busy, 1'b0);
    check("simul error pulse", error, 1'b1);
    repeat (2) @(negedge clk);
    check("simul error count", err_cnt - e0, 1);

    // Asynchronous reset mid-frame
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10);
    check("midframe busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", busy, 1'b0);
    check("async reset strobes", {sram_wr_en, sram_rd_en, error, result_valid}, 4'b0000);
    check("async reset address", sram_address, 32'd0);
    check("async reset result", result_data, 32'd0);
    last_result = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02); send_byte(8'h33);
    check("post reset wr_en", sram_wr_en, 1'b1);
    check("post reset address", sram_address, 24'h010002);
    @(negedge clk);
    complete(8'h00);
    check("post reset busy", busy, 1'b0);

    // Reset while the read strobe is high
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    check("pre reset rd_en", sram_rd_en, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("reset kills rd_en", sram_rd_en, 1'b0);
    check("reset kills busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef CMD_TIMEOUT_EN
    // Partial frame times out
    e0 = err_cnt; r0 = rd_cnt;
    send_byte(8'h52); send_byte(8'h00);
    seen = 1'b0;
    for (int c = 0; c < TMO + 10 && !seen; c++) begin
      @(negedge clk);
      if (error) seen = 1'b1;
    end
    check("timeout error seen", seen, 1'b1);
    check("timeout idle", busy, 1'b0);
    repeat (2) @(negedge clk);
    check("timeout no rd_en", rd_cnt - r0, 0);
    check("timeout one error", err_cnt - e0, 1);
`else
    // Partial frame waits indefinitely, then completes
    e0 = err_cnt;
    send_byte(8'h52); send_byte(8'h00);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (error) seen = 1'b1;
    end
    check("no timeout error", seen, 1'b0);
    check("no timeout busy", busy, 1'b1);
    send_byte(8'h00); send_byte(8'h00);
    check("late frame rd_en", sram_rd_en, 1'b1);
    check("late frame address", sram_address, 24'h000000);
    @(negedge clk);
    complete(8'h6B);
    check("late frame result", {result_valid, result_data}, {1'b1, 8'h6B});
    repeat (2) @(negedge clk);
    check("late frame no error", err_cnt - e0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
